shift_sequencer: RTL and testbench

Multi-cycle controller that sequences ARMv7 operand-2 shifts (LSL, LSR, ASR, ROR, RRX) for the execute stage. It applies the ARM special-case encodings, accepts one request at a time over a valid/ready handshake, and iterates the shift in bounded steps per cycle so that no full 32-bit barrel shifter sits on the critical path. It sits between decode/register read and the ALU operand-2 input and produces both the shifted value and the shifter carry-out.

---
 rtl/shift_sequencer_if.sv | 26 ++
 rtl/shift_sequencer.sv | 150 +++++++++++++++
 tb/tb_shift_sequencer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// Request/response bundle for the ARM operand-2 shift sequencer.
// slave faces the sequencer; master faces the decode/ALU side driving requests.
interface shift_sequencer_if;
  logic        Req_Valid;
  logic        Req_Ready;
  logic [2:0]  SHIFT_OP;
  logic        Shift_Imm;
  logic [31:0] Shift_Data;
  logic [7:0]  Shift_Num;
  logic        Carry_In;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [31:0] Shift_Out;
  logic        Shift_Carry_Out;
  logic        Busy;

  modport slave (
    input  Req_Valid, SHIFT_OP, Shift_Imm, Shift_Data, Shift_Num, Carry_In, Out_Ready,
    output Req_Ready, Out_Valid, Shift_Out, Shift_Carry_Out, Busy
  );

  modport master (
    output Req_Valid, SHIFT_OP, Shift_Imm, Shift_Data, Shift_Num, Carry_In, Out_Ready,
    input  Req_Ready, Out_Valid, Shift_Out, Shift_Carry_Out, Busy
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle ARMv7 operand-2 shifter: normalises the ARM shift encoding at accept,
// then shifts at most STEP bits per cycle to keep a full barrel shifter off the critical path.
module shift_sequencer #(
  parameter int STEP = 8
) (
  input  logic               clk,
  input  logic               rst,
  shift_sequencer_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [2:0] {K_LSL, K_LSR, K_ASR, K_ROR, K_RRX} kind_t;

  state_t      state, state_next;
  kind_t       kind, norm_kind;
  logic [31:0] value, norm_value, step_value;
  logic        carry, norm_carry, step_carry;
  logic [5:0]  remaining, norm_amount, k;
  logic [4:0]  imm_amount;
  logic [7:0]  num;
  logic [63:0] wide;

  // Encoding normalisation; an effective amount of 0 means the result is ready at accept.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    imm_amount  = bus.Shift_Num[4:0];
    num         = bus.Shift_Num;
    norm_kind   = K_LSL;
    norm_amount = '0;
    norm_value  = bus.Shift_Data;
    norm_carry  = bus.Carry_In;
    case (bus.SHIFT_OP)
      3'b000: begin
        norm_kind = K_LSL;
        if (bus.Shift_Imm)     norm_amount = {1'b0, imm_amount};
        else if (num > 8'd33)  norm_amount = 6'd33;
        else                   norm_amount = num[5:0];
      end
      3'b001, 3'b010: begin
        norm_kind = (bus.SHIFT_OP == 3'b001) ? K_LSR : K_ASR;
        if (bus.Shift_Imm)
          norm_amount = (imm_amount == 5'd0) ? 6'd32 : {1'b0, imm_amount};
        else if (bus.SHIFT_OP == 3'b001)
          norm_amount = (num > 8'd33) ? 6'd33 : num[5:0];
        else
          norm_amount = (num > 8'd32) ? 6'd32 : num[5:0];
      end
      3'b011: begin
        if (bus.Shift_Imm && imm_amount == 5'd0) begin
          norm_kind   = K_RRX;
          norm_amount = 6'd1;
        end else begin
          norm_kind   = K_ROR;
          norm_amount = bus.Shift_Imm ? {1'b0, imm_amount} : {1'b0, num[4:0]};
          // Non-zero multiple of 32: value unchanged, carry is the top bit.
          if (!bus.Shift_Imm && num != 8'd0 && num[4:0] == 5'd0)
            norm_carry = bus.Shift_Data[31];
        end
      end
      3'b100: begin
        norm_kind   = K_RRX;
        norm_amount = 6'd1;
      end
      default: ;
    endcase
  end

  // One bounded step; the 64-bit window makes bits shifted past position 32 read as zero.
  always_comb begin
    k          = (remaining > 6'(STEP)) ? 6'(STEP) : remaining;
    wide       = '0;
    step_value = value;
    step_carry = carry;
    case (kind)
      K_LSL: begin
        wide       = {32'b0, value} << k;
        step_value = wide[31:0];
        step_carry = wide[32];
      end
      K_LSR: begin
        wide       = {value, 32'b0} >> k;
        step_value = wide[63:32];
        step_carry = wide[31];
      end
      K_ASR: begin
        wide       = $signed({value, 32'b0}) >>> k;
        step_value = wide[63:32];
        step_carry = wide[31];
      end
      K_ROR: begin
        wide       = {value, value} >> k;
        step_value = wide[31:0];
        step_carry = wide[31];
      end
      K_RRX: begin
        step_value = {carry, value[31:1]};
        step_carry = value[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.Req_Valid) state_next = (norm_amount == 6'd0) ? DONE : SHIFT;
      SHIFT:   if (remaining == k) state_next = DONE;
      DONE:    if (bus.Out_Ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.Req_Ready = (state == IDLE) && !rst;
    bus.Out_Valid = (state == DONE);
    bus.Busy      = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value     <= '0;
      carry     <= 1'b0;
      remaining <= '0;
      kind      <= K_LSL;
    end else begin
      case (state)
        IDLE: if (bus.Req_Valid) begin
          value     <= norm_value;
          carry     <= norm_carry;
          remaining <= norm_amount;
          kind      <= norm_kind;
        end
        SHIFT: begin
          value     <= step_value;
          carry     <= step_carry;
          remaining <= remaining - k;
        end
        default: ;
      endcase
    end
  end

  assign bus.Shift_Out       = value;
  assign bus.Shift_Carry_Out = carry;
endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer (STEP = 8): directed encodings, backpressure,
// mid-operation reset and randomised requests checked against a bit-serial model.
module tb_shift_sequencer;
  localparam int STEP = 8;

  typedef struct {
    logic [2:0]  op;
    logic        imm;
    logic [31:0] data;
    logic [7:0]  num;
    logic        cin;
    logic [31:0] r;
    logic        c;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests  = 0;
  int   failed = 0;
  vec_t sb[$];

  shift_sequencer_if bus();

  shift_sequencer #(.STEP(STEP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [2:0] op, input logic imm, input logic [31:0] data,
                              input logic [7:0] num, input logic cin, input logic [31:0] r,
                              input logic c, input int lat);
    vec_t v;
    v.op = op; v.imm = imm; v.data = data; v.num = num; v.cin = cin;
    v.r = r; v.c = c; v.lat = lat;
    return v;
  endfunction

  // Bit-serial reference: one single-bit shift per iteration.
  function automatic vec_t model(input logic [2:0] op, input logic imm, input logic [31:0] d,
                                 input logic [7:0] num, input logic cin);
    vec_t v;
    int   n, kind, eff;
    v = mk(op, imm, d, num, cin, d, cin, 0);
    if (op >= 3'd5) return v;
    kind = int'(op);
    if (imm) begin
      n = int'(num[4:0]);
      if (n == 0 && (op == 3'd1 || op == 3'd2)) n = 32;
      if (n == 0 && op == 3'd3) kind = 4;
    end else begin
      n = int'(num);
    end
    if (kind == 4) begin
      v.r = {cin, d[31:1]}; v.c = d[0]; v.lat = 1;
      return v;
    end
    if (n == 0) return v;
    if (kind == 3) begin
      if (n % 32 == 0) begin v.c = d[31]; return v; end
      n = n % 32;
    end
    for (int i = 0; i < n; i++) begin
      case (kind)
        0:       begin v.c = v.r[31]; v.r = {v.r[30:0], 1'b0}; end
        1:       begin v.c = v.r[0];  v.r = {1'b0, v.r[31:1]}; end
        2:       begin v.c = v.r[0];  v.r = {v.r[31], v.r[31:1]}; end
        default: begin v.c = v.r[0];  v.r = {v.r[0], v.r[31:1]}; end
      endcase
    end
    eff = (kind <= 1) ? ((n > 33) ? 33 : n) : (kind == 2) ? ((n > 32) ? 32 : n) : n;
    v.lat = (eff + STEP - 1) / STEP;
    return v;
  endfunction

  // Drives one request, waits for the result, optionally consumes it.
  task automatic send(input vec_t v, input bit consume,
                      output logic [31:0] r, output logic c, output int lat);
    int guard = 0;
    @(negedge clk);
    bus.SHIFT_OP = v.op; bus.Shift_Imm = v.imm; bus.Shift_Data = v.data;
    bus.Shift_Num = v.num; bus.Carry_In = v.cin; bus.Req_Valid = 1'b1;
    while (bus.Req_Ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) begin
      tests++; failed++;
      $display("FAIL accept_timeout: Req_Ready never rose");
    end
    @(posedge clk); #1;
    // Scramble inputs after accept: the registered request must be unaffected.
    bus.Req_Valid = 1'b0; bus.SHIFT_OP = 3'($urandom); bus.Shift_Data = $urandom;
    bus.Shift_Num = 8'($urandom); bus.Carry_In = 1'($urandom); bus.Shift_Imm = 1'($urandom);
    lat = 0;
    while (bus.Out_Valid !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
    r = bus.Shift_Out;
    c = bus.Shift_Carry_Out;
    if (consume) begin
      bus.Out_Ready = 1'b1;
      @(posedge clk); #1;
      bus.Out_Ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.Req_Ready, bus.Out_Valid, bus.Busy, bus.Shift_Out, bus.Shift_Carry_Out} !== 36'h0) begin
      failed++;
      $display("FAIL reset_state: ready=%b valid=%b busy=%b out=%h carry=%b, expected all zero",
               bus.Req_Ready, bus.Out_Valid, bus.Busy, bus.Shift_Out, bus.Shift_Carry_Out);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (bus.Req_Ready !== 1'b1) begin
      failed++;
      $display("FAIL reset_release_ready: got %b, expected 1", bus.Req_Ready);
    end
  endtask

  task automatic test_directed(input string name, input vec_t vs[$]);
    logic [31:0] r; logic c; int lat; vec_t e;
    foreach (vs[i]) begin
      sb.push_back(vs[i]);
      send(vs[i], 1'b1, r, c, lat);
      e = sb.pop_front();
      tests++;
      if (r !== e.r || c !== e.c) begin
        failed++;
        $display("FAIL %s[%0d] result: out=%h carry=%b, expected out=%h carry=%b",
                 name, i, r, c, e.r, e.c);
      end
      tests++;
      if (lat != e.lat) begin
        failed++;
        $display("FAIL %s[%0d] latency: %0d edges, expected %0d", name, i, lat, e.lat);
      end
    end
  endtask

  task automatic test_shifts();
    vec_t q[$];
    q.push_back(mk(3'd0, 1'b0, 32'h8000_0001, 8'd32, 1'b0, 32'h0000_0000, 1'b1, 4));
    q.push_back(mk(3'd0, 1'b0, 32'h8000_0001, 8'd40, 1'b0, 32'h0000_0000, 1'b0, 5));
    q.push_back(mk(3'd0, 1'b1, 32'h0F00_0001, 8'd4,  1'b1, 32'hF000_0010, 1'b0, 1));
    q.push_back(mk(3'd1, 1'b1, 32'h8000_0000, 8'd0,  1'b0, 32'h0000_0000, 1'b1, 4));
    q.push_back(mk(3'd2, 1'b1, 32'h8000_0000, 8'd0,  1'b0, 32'hFFFF_FFFF, 1'b1, 4));
    q.push_back(mk(3'd2, 1'b0, 32'h8000_0000, 8'd200, 1'b0, 32'hFFFF_FFFF, 1'b1, 4));
    q.push_back(mk(3'd1, 1'b0, 32'hFFFF_FFFF, 8'd33, 1'b1, 32'h0000_0000, 1'b0, 5));
    test_directed("lsl_lsr_asr", q);
  endtask

  task automatic test_ror_rrx();
    vec_t q[$];
    q.push_back(mk(3'd3, 1'b0, 32'h0000_00F1, 8'd36, 1'b0, 32'h1000_000F, 1'b0, 1));
    q.push_back(mk(3'd3, 1'b0, 32'h8000_0001, 8'd64, 1'b0, 32'h8000_0001, 1'b1, 0));
    q.push_back(mk(3'd3, 1'b0, 32'h1234_5678, 8'd8,  1'b1, 32'h7812_3456, 1'b0, 1));
    q.push_back(mk(3'd3, 1'b1, 32'h0000_0003, 8'd0,  1'b1, 32'h8000_0001, 1'b1, 1));
    q.push_back(mk(3'd4, 1'b0, 32'h0000_0002, 8'd9,  1'b0, 32'h0000_0001, 1'b0, 1));
    test_directed("ror_rrx", q);
  endtask

  task automatic test_no_shift();
    vec_t q[$];
    q.push_back(mk(3'd0, 1'b0, 32'hDEAD_BEEF, 8'd0, 1'b1, 32'hDEAD_BEEF, 1'b1, 0));
    q.push_back(mk(3'd0, 1'b1, 32'h1357_9BDF, 8'd0, 1'b0, 32'h1357_9BDF, 1'b0, 0));
    q.push_back(mk(3'd6, 1'b0, 32'h0000_1234, 8'd5, 1'b1, 32'h0000_1234, 1'b1, 0));
    test_directed("no_shift", q);
  endtask

  task automatic test_backpressure();
    logic [31:0] r; logic c; int lat; vec_t e;
    sb.push_back(mk(3'd0, 1'b0, 32'h0000_0001, 8'd4, 1'b0, 32'h0000_0010, 1'b0, 1));
    send(sb[0], 1'b0, r, c, lat);
    e = sb.pop_front();
    tests++;
    if (r !== e.r || c !== e.c) begin
      failed++;
      $display("FAIL bp_result: out=%h carry=%b, expected out=%h carry=%b", r, c, e.r, e.c);
    end
    // Second request held on the bus while the first result is stalled.
    bus.SHIFT_OP = 3'd1; bus.Shift_Imm = 1'b0; bus.Shift_Data = 32'h0000_0002;
    bus.Shift_Num = 8'd1; bus.Carry_In = 1'b1; bus.Req_Valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (bus.Out_Valid !== 1'b1 || bus.Req_Ready !== 1'b0 || bus.Shift_Out !== e.r ||
          bus.Shift_Carry_Out !== e.c) begin
        failed++;
        $display("FAIL bp_hold[%0d]: valid=%b ready=%b out=%h carry=%b, expected 1 0 %h %b",
                 i, bus.Out_Valid, bus.Req_Ready, bus.Shift_Out, bus.Shift_Carry_Out, e.r, e.c);
      end
    end
    bus.Out_Ready = 1'b1;
    @(posedge clk); #1;
    bus.Out_Ready = 1'b0;
    tests++;
    if (bus.Busy !== 1'b0 || bus.Req_Ready !== 1'b1) begin
      failed++;
      $display("FAIL bp_idle_return: busy=%b ready=%b, expected 0 1", bus.Busy, bus.Req_Ready);
    end
    @(posedge clk); #1;
    bus.Req_Valid = 1'b0;
    tests++;
    if (bus.Busy !== 1'b1) begin
      failed++;
      $display("FAIL bp_second_accept: busy=%b, expected 1", bus.Busy);
    end
    @(posedge clk); #1;
    tests++;
    if (bus.Out_Valid !== 1'b1 || bus.Shift_Out !== 32'h0000_0001 || bus.Shift_Carry_Out !== 1'b0) begin
      failed++;
      $display("FAIL bp_second_result: valid=%b out=%h carry=%b, expected 1 00000001 0",
               bus.Out_Valid, bus.Shift_Out, bus.Shift_Carry_Out);
    end
    bus.Out_Ready = 1'b1;
    @(posedge clk); #1;
    bus.Out_Ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    vec_t q[$];
    @(negedge clk);
    bus.SHIFT_OP = 3'd0; bus.Shift_Imm = 1'b0; bus.Shift_Data = 32'hFFFF_FFFF;
    bus.Shift_Num = 8'd33; bus.Carry_In = 1'b1; bus.Req_Valid = 1'b1;
    @(posedge clk); #1;
    bus.Req_Valid = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (bus.Busy !== 1'b1 || bus.Out_Valid !== 1'b0) begin
      failed++;
      $display("FAIL mid_shift_state: busy=%b valid=%b, expected 1 0", bus.Busy, bus.Out_Valid);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({bus.Req_Ready, bus.Out_Valid, bus.Busy, bus.Shift_Out, bus.Shift_Carry_Out} !== 36'h0) begin
      failed++;
      $display("FAIL mid_reset_clear: ready=%b valid=%b busy=%b out=%h carry=%b, expected all zero",
               bus.Req_Ready, bus.Out_Valid, bus.Busy, bus.Shift_Out, bus.Shift_Carry_Out);
    end
    @(negedge clk);
    rst = 1'b0;
    q.push_back(mk(3'd1, 1'b0, 32'h0000_00FF, 8'd4, 1'b0, 32'h0000_000F, 1'b1, 1));
    test_directed("after_reset", q);
  endtask

  task automatic test_random();
    vec_t q[$];
    logic [2:0] op; logic imm; logic [31:0] d; logic [7:0] num; logic cin;
    for (int i = 0; i < 40; i++) begin
      op  = 3'($urandom_range(0, 7));
      imm = 1'($urandom);
      d   = $urandom;
      num = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 40));
      cin = 1'($urandom);
      q.push_back(model(op, imm, d, num, cin));
    end
    test_directed("random", q);
  endtask

  initial begin
    bus.Req_Valid = 1'b0; bus.SHIFT_OP = 3'd0; bus.Shift_Imm = 1'b0; bus.Shift_Data = '0;
    bus.Shift_Num = '0; bus.Carry_In = 1'b0; bus.Out_Ready = 1'b0;
    test_reset();
    test_shifts();
    test_ror_rrx();
    test_no_shift();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
